// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the TSC instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned WORD_SIZE = 16;

  // OPCODE_NOP encoding: opcode 4'hF, function code 6'd28
  localparam logic [WORD_SIZE-1:0] INST_NOP = 16'hF01C;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] pc_plus1;
    logic                 valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: INST_NOP, pc_plus1: '0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read
// handshake and loads the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 inputReady,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic [WORD_SIZE-1:0] IF_ID_instr,
  output logic [WORD_SIZE-1:0] IF_ID_pc_plus1,
  output logic                 IF_ID_valid,
  output logic [WORD_SIZE-1:0] fetch_count
);

  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] discard_q, discard_d;
  logic [WORD_SIZE-1:0] buf_instr_q, buf_instr_d;
  logic [WORD_SIZE-1:0] buf_pc1_q, buf_pc1_d;
  if_id_t               if_id_q, if_id_d;
  logic [WORD_SIZE-1:0] count_q, count_d;
  logic                 load_en;
  if_id_t               load_val;
  logic [WORD_SIZE-1:0] pc_plus1;

  assign pc_plus1 = pc_q + WORD_SIZE'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      discard_q   <= '0;
      buf_instr_q <= '0;
      buf_pc1_q   <= '0;
      if_id_q     <= IF_ID_BUBBLE;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      buf_instr_q <= buf_instr_d;
      buf_pc1_q   <= buf_pc1_d;
      if_id_q     <= if_id_d;
      count_q     <= count_d;
    end
  end

  // Next-state: halt > redirect > stall > normal; flush overrides any IF/ID load
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    buf_instr_d = buf_instr_q;
    buf_pc1_d   = buf_pc1_q;
    if_id_d     = if_id_q;
    count_d     = count_q;
    load_en     = 1'b0;
    load_val    = IF_ID_BUBBLE;

    if (halt) begin
      state_d = ST_HALT;
      if_id_d = IF_ID_BUBBLE;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (redirect_valid) begin
            pc_d = redirect_pc;
            if (!inputReady) begin
              discard_d = pc_q;
              state_d   = ST_DISCARD;
            end
          end else if (inputReady) begin
            pc_d = pc_plus1;
            if (stall) begin
              buf_instr_d = i_data;
              buf_pc1_d   = pc_plus1;
              state_d     = ST_HOLD;
            end else begin
              load_en  = 1'b1;
              load_val = '{instr: i_data, pc_plus1: pc_plus1, valid: 1'b1};
            end
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = ST_FETCH;
          end else if (!stall) begin
            load_en  = 1'b1;
            load_val = '{instr: buf_instr_q, pc_plus1: buf_pc1_q, valid: 1'b1};
            state_d  = ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (redirect_valid) pc_d = redirect_pc;
          if (inputReady) state_d = ST_FETCH;
        end
        default: ;
      endcase

      if (flush) begin
        if_id_d = IF_ID_BUBBLE;
      end else if (load_en) begin
        if_id_d = load_val;
        count_d = count_q + WORD_SIZE'(1);
      end
    end
  end

  assign i_readM   = !reset && (state_q == ST_FETCH || state_q == ST_DISCARD);
  assign i_address = (state_q == ST_DISCARD) ? discard_q : pc_q;

  assign IF_ID_instr    = if_id_q.instr;
  assign IF_ID_pc_plus1 = if_id_q.pc_plus1;
  assign IF_ID_valid    = if_id_q.valid;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 inputReady;
  logic                 stall;
  logic                 flush;
  logic                 redirect_valid;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 halt;
  logic [WORD_SIZE-1:0] IF_ID_instr;
  logic [WORD_SIZE-1:0] IF_ID_pc_plus1;
  logic                 IF_ID_valid;
  logic [WORD_SIZE-1:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .i_readM(i_readM), .i_address(i_address),
    .i_data(i_data), .inputReady(inputReady), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .IF_ID_instr(IF_ID_instr), .IF_ID_pc_plus1(IF_ID_pc_plus1),
    .IF_ID_valid(IF_ID_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] instr,
                            input logic [15:0] pc1, input logic valid);
    check({tag, ".instr"}, IF_ID_instr, instr);
    check({tag, ".pc1"}, IF_ID_pc_plus1, pc1);
    check({tag, ".valid"}, 16'(IF_ID_valid), 16'(valid));
  endtask

  initial begin
    reset = 1'b1; i_data = '0; inputReady = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;

    // reset state
    tick();
    check("rst.readM", 16'(i_readM), 16'd0);
    check_ifid("rst", 16'hF01C, 16'h0000, 1'b0);
    check("rst.count", fetch_count, 16'd0);
    reset = 1'b0;
    #1;
    check("first.readM", 16'(i_readM), 16'd1);
    check("first.addr", i_address, 16'h0000);

    // zero-wait streaming
    inputReady = 1'b1; i_data = 16'h6001;
    tick();
    check_ifid("s0", 16'h6001, 16'h0001, 1'b1);
    check("s0.addr", i_address, 16'h0001);
    i_data = 16'h6102;
    tick();
    check_ifid("s1", 16'h6102, 16'h0002, 1'b1);
    check("s1.addr", i_address, 16'h0002);
    check("s1.count", fetch_count, 16'd2);
    for (int i = 0; i < 3; i++) begin
      i_data = 16'h1110 + 16'(i);
      tick();
    end
    check("adv.addr", i_address, 16'h0005);
    check("adv.count", fetch_count, 16'd5);
    check_ifid("adv", 16'h1112, 16'h0005, 1'b1);

    // stall while data returns at pc=5
    stall = 1'b1; i_data = 16'h4A05;
    tick();
    check("hold0.readM", 16'(i_readM), 16'd0);
    check_ifid("hold0", 16'h1112, 16'h0005, 1'b1);
    inputReady = 1'b0; i_data = 16'hBEEF;
    tick();
    tick();
    check("hold2.readM", 16'(i_readM), 16'd0);
    check_ifid("hold2", 16'h1112, 16'h0005, 1'b1);
    check("hold2.count", fetch_count, 16'd5);
    stall = 1'b0;
    tick();
    check_ifid("unhold", 16'h4A05, 16'h0006, 1'b1);
    check("unhold.count", fetch_count, 16'd6);
    check("unhold.readM", 16'(i_readM), 16'd1);
    check("unhold.addr", i_address, 16'h0006);

    // redirect during a wait cycle -> discard old access
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    check("disc0.readM", 16'(i_readM), 16'd1);
    check("disc0.addr", i_address, 16'h0006);
    tick();
    check("disc1.addr", i_address, 16'h0006);
    inputReady = 1'b1; i_data = 16'hDEAD;
    tick();
    check("redir.addr", i_address, 16'h0040);
    check_ifid("redir", 16'h4A05, 16'h0006, 1'b1);
    check("redir.count", fetch_count, 16'd6);
    i_data = 16'h7777;
    tick();
    check_ifid("tgt", 16'h7777, 16'h0041, 1'b1);
    check("tgt.count", fetch_count, 16'd7);

    // flush with stall clears IF/ID
    inputReady = 1'b0; flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    check_ifid("flush", 16'hF01C, 16'h0000, 1'b0);
    check("flush.addr", i_address, 16'h0041);

    // redirect with data ready drops data; then wrap at 16'hFFFF
    inputReady = 1'b1; i_data = 16'h9999;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    check("wrapA.addr", i_address, 16'hFFFF);
    check("wrapA.count", fetch_count, 16'd7);
    check("wrapA.valid", 16'(IF_ID_valid), 16'd0);
    i_data = 16'h1234;
    tick();
    check_ifid("wrap", 16'h1234, 16'h0000, 1'b1);
    check("wrap.addr", i_address, 16'h0000);
    check("wrap.count", fetch_count, 16'd8);

    // halt mid-request, later inputReady ignored
    inputReady = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt.readM", 16'(i_readM), 16'd0);
    check_ifid("halt", 16'hF01C, 16'h0000, 1'b0);
    inputReady = 1'b1; i_data = 16'h5555;
    tick();
    tick();
    check("halted.readM", 16'(i_readM), 16'd0);
    check("halted.count", fetch_count, 16'd8);
    check("halted.valid", 16'(IF_ID_valid), 16'd0);

    // reset leaves HALT
    inputReady = 1'b0; reset = 1'b1;
    tick();
    check("rst2.readM", 16'(i_readM), 16'd0);
    reset = 1'b0;
    #1;
    check("rst2.readM1", 16'(i_readM), 16'd1);
    check("rst2.addr", i_address, 16'h0000);
    check("rst2.count", fetch_count, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined TSC CPU: owns the PC, runs the read handshake with instruction memory, and loads the IF/ID pipeline register. Decode and the control unit consume its output. It honours stall/flush from the hazard logic, PC redirects from ID/EX (jump, JPR/JRL, taken branch) and halt from WB.

## Interface
- WORD_SIZE, 16, width of PC, address and instruction
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- i_readM  out  1  instruction-memory read request
- i_address  out  WORD_SIZE  request address; stable while i_readM=1 until the request completes
- i_data  in  WORD_SIZE  fetched instruction, valid when inputReady=1
- inputReady  in  1  memory completion; sampled at the clock edge while i_readM=1
- stall  in  1  hold the IF/ID register and PC (load-use / structural hazard)
- flush  in  1  replace the IF/ID contents with a bubble
- redirect_valid  in  1  PC change request
- redirect_pc  in  WORD_SIZE  new PC target
- halt  in  1  stop fetching (is_halted from WB)
- IF_ID_instr  out  WORD_SIZE  instruction to decode
- IF_ID_pc_plus1  out  WORD_SIZE  address of fetched instruction + 1; used for JAL/JRL link and branch base
- IF_ID_valid  out  1  1 = real instruction, 0 = bubble
- fetch_count  out  WORD_SIZE  number of instructions loaded into IF/ID, wraps

## Operation
- States: FETCH, HOLD, DISCARD, HALT. Reset enters FETCH.
- Reset values:
  - pc=RESET_PC; IF_ID_instr=INST_NOP; IF_ID_pc_plus1=0; IF_ID_valid=0; fetch_count=0.
  - i_readM=0 during the reset cycle. The hold buffer and discard_addr are cleared.
- Outputs are Moore from state:
  - i_readM=1 in FETCH and DISCARD, 0 in HOLD and HALT.
  - i_address = discard_addr in DISCARD, pc otherwise.
- Priority each cycle: reset > halt > redirect_valid > stall > normal.
- FETCH:
  - inputReady & !stall: IF/ID <= {i_data, pc+1, 1}; pc <= pc+1; fetch_count++; stay in FETCH.
  - inputReady & stall: buf <= {i_data, pc+1}; pc <= pc+1; go to HOLD.
  - No inputReady: hold the request; pc is unchanged.
- HOLD:
  - stall=0: IF/ID <= {buf, 1}; fetch_count++; go to FETCH.
  - stall=1: hold.
- Redirect:
  - From FETCH with inputReady=0: discard_addr <= pc; pc <= redirect_pc; go to DISCARD (the outstanding access must complete before a new address is presented).
  - From FETCH with inputReady=1: data is dropped; pc <= redirect_pc; stay in FETCH.
  - From HOLD: buffer is dropped; pc <= redirect_pc; go to FETCH.
  - From DISCARD: pc <= redirect_pc; stay in DISCARD.
  - Redirect never loads IF/ID. IF/ID is cleared only by flush.
- DISCARD: on inputReady, drop i_data and go to FETCH. stall has no effect in this state.
- flush: IF/ID <= {INST_NOP, 0, 0} regardless of stall; a simultaneous FETCH load is suppressed. pc/state behaviour is unchanged, and flush alone never drops the in-flight fetch.
- stall without flush holds all IF/ID fields.
- halt: go to HALT from any state; IF/ID becomes a bubble; a later inputReady is ignored. Only reset leaves HALT.
- Arithmetic: pc+1 and fetch_count wrap modulo 2^WORD_SIZE (16'hFFFF -> 16'h0000).

## Timing
- First request: i_readM=1, i_address=RESET_PC in the first cycle after reset deasserts.
- Latency: with inputReady in the request cycle, the instruction appears on IF_ID_* after the next edge, i.e. 1 cycle.
- Throughput: 1 instruction/cycle with zero-wait memory. With each extra memory wait cycle, fetch slows by one cycle.
- HOLD -> IF/ID transfer happens at the edge where stall is first sampled 0. The next request issues the cycle after that, leaving a one-cycle fetch gap.
- Redirect with no pending DISCARD: the request to redirect_pc appears the cycle after redirect_valid is sampled.

## Structure
- Constants go in the shared constants.v: INST_NOP (OPCODE_NOP encoding), the fetch state encodings, and WORD_SIZE.
- No sub-module is needed. The HOLD buffer is an inline one-entry register; the IF/ID register lives in this block.

## Test plan
- Reset, then zero-wait memory returning 16'h6001, 16'h6102 -> i_address 0,1,2 on consecutive cycles; IF_ID_instr 6001 then 6102; IF_ID_pc_plus1 1 then 2; fetch_count=2.
- stall=1 for 3 cycles while inputReady returns 16'h4A05 at pc=5 -> state HOLD, i_readM=0, IF/ID unchanged; when stall falls, IF_ID_instr=4A05 and IF_ID_pc_plus1=6; the next request is at address 6.
- Memory with 2 wait cycles; redirect_valid to 16'h0040 in the first wait cycle -> i_address stays at the old pc until inputReady; that data is dropped; the next request is 16'h0040 and IF/ID is never loaded with the dropped word.
- flush and stall together while IF/ID holds a valid instruction -> IF_ID_valid=0, IF_ID_instr=INST_NOP after the edge.
- pc=16'hFFFF with fetch completing -> IF_ID_pc_plus1=0; next i_address=16'h0000.
- halt asserted mid-request, then inputReady arrives -> i_readM=0 from the next cycle; IF/ID is a bubble; fetch_count is frozen until reset; after reset, i_address=RESET_PC.
